// File: rtl/async_fifo_rd_upsizer_pkg.sv
// Shared defaults and width helper for the FIFO read-side upsizer.
package async_fifo_rd_upsizer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RATIO      = 4;

  // Lane counter must hold 0..ratio inclusive.
  function automatic int lane_cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_upsizer_oreg.sv
// Output holding register for the wide word: valid/ready handshake where a new
// load takes priority over the accept of the word currently held.
module async_fifo_rd_upsizer_oreg
  import async_fifo_rd_upsizer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH * DEF_RATIO,
  parameter int CNT_WIDTH  = lane_cnt_width(DEF_RATIO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [CNT_WIDTH-1:0]  load_count,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_last
);

  // Payload only changes on load, so it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_count <= {CNT_WIDTH{1'b0}};
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_count <= load_count;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/async_fifo_rd_upsizer.sv
// Read-side gearbox: pops narrow FWFT FIFO words, packs RATIO of them into one
// wide word on a valid/ready output, and emits partial words on flush.
module async_fifo_rd_upsizer
  import async_fifo_rd_upsizer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int RATIO      = DEF_RATIO,
  localparam int CNT_WIDTH  = lane_cnt_width(RATIO)
) (
  input  logic                        rd_clk,
  input  logic                        rst_n,
  input  logic                        fifo_has_data,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        fifo_rd_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        out_last,
  output logic                        busy
);

  localparam int                   OUT_WIDTH = DATA_WIDTH * RATIO;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]           rst_sync;
  logic                 run_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] wr_idx;
  logic                 flush_pend;
  logic                 flush_pend_next;
  logic                 full;
  logic                 xfer;
  logic                 pop;
  logic [OUT_WIDTH-1:0] load_data;

  // Release is synchronised; run_q adds one more cycle before pops may start.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
      run_q    <= 1'b0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      run_q    <= rst_sync[1];
    end
  end

  assign full       = (cnt == CNT_FULL);
  assign xfer       = run_q & (~out_valid | out_ready) & (full | (flush_pend & (cnt != CNT_ZERO)));
  assign pop        = run_q & fifo_has_data & ~flush_pend & (~full | xfer);
  assign fifo_rd_en = pop;
  assign busy       = (cnt != CNT_ZERO) | out_valid | flush_pend;

  // A word popped in the transfer cycle starts the next word in lane 0.
  always_comb begin
    cnt_next        = cnt;
    wr_idx          = cnt;
    flush_pend_next = flush_pend;
    if (xfer) begin
      wr_idx   = CNT_ZERO;
      cnt_next = pop ? CNT_ONE : CNT_ZERO;
    end else begin
      cnt_next = cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
    end
    if (flush_pend) begin
      flush_pend_next = ~(xfer | (cnt == CNT_ZERO));
    end else begin
      flush_pend_next = flush & run_q;
    end
  end

  // Lane counter and pending-flush state.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= CNT_ZERO;
      flush_pend <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      flush_pend <= flush_pend_next;
    end
  end

  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    localparam logic [CNT_WIDTH-1:0] LANE = CNT_WIDTH'(l);
    logic                  lane_we;
    logic [DATA_WIDTH-1:0] lane_q;

    assign lane_we = pop & (wr_idx == LANE);

    // One accumulator lane, written only when the pop targets it.
    always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= {DATA_WIDTH{1'b0}};
      end else if (lane_we) begin
        lane_q <= fifo_rd_data;
      end
    end

    // Lanes not filled in this word go out as zero rather than stale data.
    assign load_data[l*DATA_WIDTH +: DATA_WIDTH] = (LANE < cnt) ? lane_q : {DATA_WIDTH{1'b0}};
  end

  async_fifo_rd_upsizer_oreg #(
    .DATA_WIDTH (OUT_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_oreg (
    .clk        (rd_clk),
    .rst_n      (rst_n),
    .load       (xfer),
    .load_data  (load_data),
    .load_count (cnt),
    .load_last  (flush_pend),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_async_fifo_rd_upsizer.sv
// Self-checking bench for async_fifo_rd_upsizer (DATA_WIDTH=8, RATIO=4).
module tb_async_fifo_rd_upsizer;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_has_data = 1'b0;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  byte unsigned src_q[$];
  byte unsigned exp_bytes[$];
  bit          toggle_mode = 1'b0;
  bit          gate = 1'b0;
  bit          rand_ready = 1'b0;
  bit          sb_on = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  int          pops = 0;

  typedef struct {
    logic        has;
    logic [7:0]  d;
    logic        fl;
    logic        e_rd;
    logic        e_v;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t tbl[24];

  always #5 rd_clk = ~rd_clk;

  async_fifo_rd_upsizer dut (
    .rd_clk        (rd_clk),
    .rst_n         (rst_n),
    .fifo_has_data (fifo_has_data),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_count     (out_count),
    .out_last      (out_last),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic has, input logic [7:0] d, input logic fl, input logic e_rd,
                              input logic e_v, input logic [31:0] e_data, input logic [2:0] e_cnt,
                              input logic e_last, input logic e_busy);
    vec_t v;
    v.has = has; v.d = d; v.fl = fl; v.e_rd = e_rd; v.e_v = e_v;
    v.e_data = e_data; v.e_cnt = e_cnt; v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive_src();
    fifo_has_data = (src_q.size() > 0) && (!toggle_mode || gate);
    fifo_rd_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  // One clock of FIFO source + consumer, with protocol and scoreboard checks.
  task automatic cycle();
    logic        rd;
    logic [31:0] w;
    @(negedge rd_clk);
    check("rd_en_without_data", {31'b0, fifo_rd_en & ~fifo_has_data}, 32'h0);
    if (prev_stall) begin
      check("hold_valid", {31'b0, out_valid}, 32'h1);
      check("hold_data", out_data, prev_data);
    end
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    rd = fifo_rd_en;
    if (sb_on && out_valid && out_ready) begin
      if (exp_bytes.size() >= 4) begin
        w = {exp_bytes[3], exp_bytes[2], exp_bytes[1], exp_bytes[0]};
        repeat (4) void'(exp_bytes.pop_front());
        check("word_data", out_data, w);
        check("word_count", {29'b0, out_count}, 32'd4);
        check("word_last", {31'b0, out_last}, 32'h0);
      end else begin
        check("extra_word", 32'h1, 32'h0);
      end
    end
    @(posedge rd_clk);
    #1;
    if (rd && src_q.size() > 0) begin
      void'(src_q.pop_front());
      pops++;
    end
    gate = ~gate;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_has_data = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    src_q.delete();
    exp_bytes.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
  endtask

  initial begin
    byte unsigned b;

    // Reset state while rst_n is low from time zero.
    @(negedge rd_clk);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", {29'b0, out_count}, 32'h0);
    check("rst_last", {31'b0, out_last}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    do_reset();

    // Full words, flush partials, lane-0 restart, flush with empty accumulator.
    tbl[0]  = mk(1, 8'h01, 0, 1, 0, 32'h0, 3'd0, 0, 0);
    tbl[1]  = mk(1, 8'h02, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[2]  = mk(1, 8'h03, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[3]  = mk(1, 8'h04, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[4]  = mk(1, 8'h05, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[5]  = mk(1, 8'h06, 0, 1, 1, 32'h04030201, 3'd4, 0, 1);
    tbl[6]  = mk(1, 8'h07, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[7]  = mk(1, 8'h08, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[9]  = mk(0, 8'h00, 0, 0, 1, 32'h08070605, 3'd4, 0, 1);
    tbl[10] = mk(1, 8'h0A, 0, 1, 0, 32'h0, 3'd0, 0, 0);
    tbl[11] = mk(1, 8'h0B, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[12] = mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[13] = mk(1, 8'h0C, 0, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[14] = mk(1, 8'h0C, 0, 1, 1, 32'h00000B0A, 3'd2, 1, 1);
    tbl[15] = mk(1, 8'h0D, 0, 1, 0, 32'h0, 3'd0, 0, 1);
    tbl[16] = mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[18] = mk(0, 8'h00, 0, 0, 1, 32'h00000D0C, 3'd2, 1, 1);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 0);
    tbl[20] = mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 0, 0);
    tbl[21] = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 1);
    tbl[22] = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 0);
    tbl[23] = mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 0, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      fifo_has_data = tbl[i].has;
      fifo_rd_data  = tbl[i].d;
      flush         = tbl[i].fl;
      @(negedge rd_clk);
      check($sformatf("t%0d_rd_en", i), {31'b0, fifo_rd_en}, {31'b0, tbl[i].e_rd});
      check($sformatf("t%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_v});
      check($sformatf("t%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      if (tbl[i].e_v) begin
        check($sformatf("t%0d_data", i), out_data, tbl[i].e_data);
        check($sformatf("t%0d_count", i), {29'b0, out_count}, {29'b0, tbl[i].e_cnt});
        check($sformatf("t%0d_last", i), {31'b0, out_last}, {31'b0, tbl[i].e_last});
      end
      @(posedge rd_clk);
      #1;
    end
    flush = 1'b0;
    fifo_has_data = 1'b0;

    // Backpressure: 12 bytes offered, consumer stalled.
    out_ready = 1'b0;
    sb_on = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      src_q.push_back(b);
      exp_bytes.push_back(b);
    end
    drive_src();
    repeat (20) cycle();
    #1;
    check("bp_pops", pops, 32'd8);
    check("bp_rd_en", {31'b0, fifo_rd_en}, 32'h0);
    check("bp_has_data", {31'b0, fifo_has_data}, 32'h1);
    check("bp_valid", {31'b0, out_valid}, 32'h1);
    check("bp_data", out_data, {exp_bytes[3], exp_bytes[2], exp_bytes[1], exp_bytes[0]});
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_bytes.size() > 0; n++) cycle();
    check("bp_drained", exp_bytes.size(), 32'd0);
    repeat (3) cycle();

    // Random: toggling has_data, random out_ready.
    toggle_mode = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom_range(0, 255));
      src_q.push_back(b);
      exp_bytes.push_back(b);
    end
    drive_src();
    for (int n = 0; n < 2000 && exp_bytes.size() > 0; n++) cycle();
    check("rand_drained", exp_bytes.size(), 32'd0);
    check("rand_src_empty", src_q.size(), 32'd0);
    toggle_mode = 1'b0;
    rand_ready = 1'b0;
    sb_on = 1'b0;
    out_ready = 1'b0;

    // Reset mid-operation with cnt=3 and a held output word.
    for (int i = 0; i < 7; i++) src_q.push_back(8'(i + 8'h40));
    drive_src();
    repeat (15) cycle();
    check("mid_valid", {31'b0, out_valid}, 32'h1);
    check("mid_src_used", src_q.size(), 32'd0);
    src_q.push_back(8'h77);
    drive_src();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_data", out_data, 32'h0);
    check("arst_count", {29'b0, out_count}, 32'h0);
    check("arst_last", {31'b0, out_last}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_rd_en", {31'b0, fifo_rd_en}, 32'h0);
    repeat (2) @(posedge rd_clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      check($sformatf("rel%0d_rd_en", i), {31'b0, fifo_rd_en}, (i == 3) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
